// File: rtl/collision_arbiter_if.sv
// Request/response bundle between the move controllers, the arbiter and the
// shared platform-collision checker.
interface collision_arbiter_if #(
    parameter int N_REQ   = 2,
    parameter int COORD_W = 10
);
    logic [N_REQ-1:0]         req;
    logic [N_REQ*COORD_W-1:0] req_x;
    logic [N_REQ*COORD_W-1:0] req_y;
    logic [N_REQ*COORD_W-1:0] req_w;
    logic [N_REQ*COORD_W-1:0] req_h;
    logic [N_REQ-1:0]         gnt;
    logic [N_REQ-1:0]         rsp_valid;
    logic [1:0]               rsp_coll;
    logic                     chk_start;
    logic [COORD_W-1:0]       chk_x;
    logic [COORD_W-1:0]       chk_y;
    logic [COORD_W-1:0]       chk_w;
    logic [COORD_W-1:0]       chk_h;
    logic                     chk_done;
    logic [1:0]               chk_coll;
    logic                     busy;
    logic                     err_timeout;

    // Requesters and checker side: drive requests and checker results.
    modport master (
        output req, req_x, req_y, req_w, req_h, chk_done, chk_coll,
        input  gnt, rsp_valid, rsp_coll, chk_start, chk_x, chk_y, chk_w, chk_h,
               busy, err_timeout
    );

    // Arbiter side.
    modport slave (
        input  req, req_x, req_y, req_w, req_h, chk_done, chk_coll,
        output gnt, rsp_valid, rsp_coll, chk_start, chk_x, chk_y, chk_w, chk_h,
               busy, err_timeout
    );
endinterface

// File: rtl/collision_arbiter.sv
// Round-robin arbiter sharing one platform-collision checker between the
// player movement controllers. One transaction at a time:
// IDLE -> ISSUE (start pulse) -> WAIT (done or timeout) -> RESP (response pulse).
module collision_arbiter #(
    parameter int N_REQ   = 2,
    parameter int COORD_W = 10,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    collision_arbiter_if.slave bus
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_WAIT  = 2'b10,
        S_RESP  = 2'b11
    } state_t;

    state_t             state_r, state_s;
    logic [IDX_W-1:0]   rr_ptr_r, rr_ptr_s, win_s;
    logic [CNT_W-1:0]   wait_cnt_r, wait_cnt_s;
    logic [N_REQ-1:0]   gnt_r, gnt_s;
    logic [N_REQ-1:0]   rsp_valid_r, rsp_valid_s;
    logic [1:0]         rsp_coll_r, rsp_coll_s;
    logic               chk_start_r, chk_start_s;
    logic [COORD_W-1:0] chk_x_r, chk_x_s, chk_y_r, chk_y_s;
    logic [COORD_W-1:0] chk_w_r, chk_w_s, chk_h_r, chk_h_s;
    logic [COORD_W-1:0] sel_x_s, sel_y_s, sel_w_s, sel_h_s;
    logic               busy_r, busy_s;
    logic               err_timeout_r, err_timeout_s;

    // First requesting index after ptr, wrapping; returns ptr when nobody requests.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] win;
        logic             found;
        int               idx;
        win   = ptr;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!found && r[IDX_W'(idx)]) begin
                win   = IDX_W'(idx);
                found = 1'b1;
            end else begin
                win   = win;
            end
        end
        return win;
    endfunction

    // Winner selection and operand mux for the requester that would be granted now.
    always_comb begin
        win_s   = rr_pick(bus.req, rr_ptr_r);
        sel_x_s = {COORD_W{1'b0}};
        sel_y_s = {COORD_W{1'b0}};
        sel_w_s = {COORD_W{1'b0}};
        sel_h_s = {COORD_W{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            sel_x_s = sel_x_s | ((IDX_W'(i) == win_s) ? bus.req_x[i*COORD_W +: COORD_W] : {COORD_W{1'b0}});
            sel_y_s = sel_y_s | ((IDX_W'(i) == win_s) ? bus.req_y[i*COORD_W +: COORD_W] : {COORD_W{1'b0}});
            sel_w_s = sel_w_s | ((IDX_W'(i) == win_s) ? bus.req_w[i*COORD_W +: COORD_W] : {COORD_W{1'b0}});
            sel_h_s = sel_h_s | ((IDX_W'(i) == win_s) ? bus.req_h[i*COORD_W +: COORD_W] : {COORD_W{1'b0}});
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_s       = state_r;
        rr_ptr_s      = rr_ptr_r;
        wait_cnt_s    = wait_cnt_r;
        gnt_s         = gnt_r;
        rsp_valid_s   = {N_REQ{1'b0}};
        rsp_coll_s    = rsp_coll_r;
        chk_start_s   = 1'b0;
        chk_x_s       = chk_x_r;
        chk_y_s       = chk_y_r;
        chk_w_s       = chk_w_r;
        chk_h_s       = chk_h_r;
        err_timeout_s = err_timeout_r;
        case (state_r)
            S_IDLE: begin
                if (|bus.req) begin
                    state_s     = S_ISSUE;
                    rr_ptr_s    = win_s;
                    gnt_s       = ONE_HOT0 << win_s;
                    chk_start_s = 1'b1;
                    chk_x_s     = sel_x_s;
                    chk_y_s     = sel_y_s;
                    chk_w_s     = sel_w_s;
                    chk_h_s     = sel_h_s;
                end else begin
                    state_s     = S_IDLE;
                end
            end
            S_ISSUE: begin
                wait_cnt_s = {CNT_W{1'b0}};
                state_s    = S_WAIT;
            end
            S_WAIT: begin
                // A done arriving together with the timeout still wins.
                if (bus.chk_done) begin
                    rsp_coll_s  = bus.chk_coll;
                    rsp_valid_s = gnt_r;
                    state_s     = S_RESP;
                end else if ((wait_cnt_r + CNT_W'(1)) == CNT_W'(TIMEOUT)) begin
                    rsp_coll_s    = 2'b00;
                    rsp_valid_s   = gnt_r;
                    err_timeout_s = 1'b1;
                    state_s       = S_RESP;
                end else begin
                    wait_cnt_s = wait_cnt_r + CNT_W'(1);
                end
            end
            S_RESP: begin
                gnt_s   = {N_REQ{1'b0}};
                state_s = S_IDLE;
            end
            default: begin
                gnt_s   = {N_REQ{1'b0}};
                state_s = S_IDLE;
            end
        endcase
        busy_s = (state_s != S_IDLE);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Round-robin pointer, wait counter and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_r      <= IDX_W'(N_REQ - 1);
            wait_cnt_r    <= {CNT_W{1'b0}};
            gnt_r         <= {N_REQ{1'b0}};
            rsp_valid_r   <= {N_REQ{1'b0}};
            rsp_coll_r    <= 2'b00;
            chk_start_r   <= 1'b0;
            chk_x_r       <= {COORD_W{1'b0}};
            chk_y_r       <= {COORD_W{1'b0}};
            chk_w_r       <= {COORD_W{1'b0}};
            chk_h_r       <= {COORD_W{1'b0}};
            busy_r        <= 1'b0;
            err_timeout_r <= 1'b0;
        end else begin
            rr_ptr_r      <= rr_ptr_s;
            wait_cnt_r    <= wait_cnt_s;
            gnt_r         <= gnt_s;
            rsp_valid_r   <= rsp_valid_s;
            rsp_coll_r    <= rsp_coll_s;
            chk_start_r   <= chk_start_s;
            chk_x_r       <= chk_x_s;
            chk_y_r       <= chk_y_s;
            chk_w_r       <= chk_w_s;
            chk_h_r       <= chk_h_s;
            busy_r        <= busy_s;
            err_timeout_r <= err_timeout_s;
        end
    end

    assign bus.gnt         = gnt_r;
    assign bus.rsp_valid   = rsp_valid_r;
    assign bus.rsp_coll    = rsp_coll_r;
    assign bus.chk_start   = chk_start_r;
    assign bus.chk_x       = chk_x_r;
    assign bus.chk_y       = chk_y_r;
    assign bus.chk_w       = chk_w_r;
    assign bus.chk_h       = chk_h_r;
    assign bus.busy        = busy_r;
    assign bus.err_timeout = err_timeout_r;
endmodule

// File: tb/tb_collision_arbiter.sv
// Bench for collision_arbiter: a transaction-level reference model (grant
// timestamps, response age, round-robin by scanning the last winner) checked
// every cycle, plus directed scenarios with literal expectations.
module tb_collision_arbiter;
    localparam int N_REQ   = 2;
    localparam int COORD_W = 10;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst = 1'b0;

    collision_arbiter_if #(.N_REQ(N_REQ), .COORD_W(COORD_W)) bus();

    collision_arbiter #(.N_REQ(N_REQ), .COORD_W(COORD_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit                 m_busy;
    int                 m_age;       // cycles since the grant edge (1 = start cycle)
    int                 m_resp_age;  // age of the response cycle, 0 while unknown
    int                 m_win;
    int                 m_last;
    logic [COORD_W-1:0] m_x, m_y, m_w, m_h;
    logic [1:0]         m_code;
    bit                 m_err;

    task automatic model_reset();
        m_busy = 1'b0; m_age = 0; m_resp_age = 0; m_win = 0; m_last = N_REQ - 1;
        m_x = '0; m_y = '0; m_w = '0; m_h = '0; m_code = 2'b00; m_err = 1'b0;
    endtask

    task automatic model_compare();
        logic [N_REQ-1:0] eg, ev;
        eg = m_busy ? N_REQ'(1 << m_win) : '0;
        ev = (m_busy && m_age == m_resp_age) ? eg : '0;
        check("m_gnt", 32'(bus.gnt), 32'(eg));
        check("m_rsp_valid", 32'(bus.rsp_valid), 32'(ev));
        check("m_chk_start", 32'(bus.chk_start), 32'(m_busy && m_age == 1));
        check("m_busy", 32'(bus.busy), 32'(m_busy));
        check("m_err_timeout", 32'(bus.err_timeout), 32'(m_err));
        check("m_chk_x", 32'(bus.chk_x), 32'(m_x));
        check("m_chk_y", 32'(bus.chk_y), 32'(m_y));
        check("m_chk_w", 32'(bus.chk_w), 32'(m_w));
        check("m_chk_h", 32'(bus.chk_h), 32'(m_h));
        if (ev != '0) check("m_rsp_coll", 32'(bus.rsp_coll), 32'(m_code));
    endtask

    // Advance the model across the coming clock edge using the inputs it will sample.
    task automatic model_advance();
        bit found;
        int idx;
        if (!m_busy) begin
            if (bus.req != '0) begin
                found = 1'b0;
                for (int k = 1; k <= N_REQ; k++) begin
                    idx = (m_last + k) % N_REQ;
                    if (!found && bus.req[idx]) begin
                        found = 1'b1;
                        m_win = idx;
                    end
                end
                m_last = m_win; m_busy = 1'b1; m_age = 1; m_resp_age = 0;
                m_x = bus.req_x[m_win*COORD_W +: COORD_W];
                m_y = bus.req_y[m_win*COORD_W +: COORD_W];
                m_w = bus.req_w[m_win*COORD_W +: COORD_W];
                m_h = bus.req_h[m_win*COORD_W +: COORD_W];
            end
        end else begin
            if (m_resp_age == 0 && m_age >= 2 && bus.chk_done) begin
                m_resp_age = m_age + 1; m_code = bus.chk_coll;
            end else if (m_resp_age == 0 && m_age == TIMEOUT + 1) begin
                m_resp_age = m_age + 1; m_code = 2'b00; m_err = 1'b1;
            end
            if (m_age == m_resp_age) m_busy = 1'b0;
            else m_age++;
        end
    endtask

    // Compare process: every falling edge, check the DUT against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (rst == 1'b0) begin
                check("rst_gnt", 32'(bus.gnt), 32'd0);
                check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
                check("rst_rsp_coll", 32'(bus.rsp_coll), 32'd0);
                check("rst_busy", 32'(bus.busy), 32'd0);
                check("rst_chk_x", 32'(bus.chk_x), 32'd0);
                check("rst_err", 32'(bus.err_timeout), 32'd0);
                model_reset();
            end else begin
                model_compare();
                model_advance();
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_ops(input int i, input int x, input int y, input int w, input int h);
        bus.req_x[i*COORD_W +: COORD_W] = COORD_W'(x);
        bus.req_y[i*COORD_W +: COORD_W] = COORD_W'(y);
        bus.req_w[i*COORD_W +: COORD_W] = COORD_W'(w);
        bus.req_h[i*COORD_W +: COORD_W] = COORD_W'(h);
    endtask

    task automatic wait_start();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (!ok) begin
                step(); mid();
                if (bus.chk_start == 1'b1) ok = 1'b1;
            end
        end
        check("chk_start_seen", 32'(ok), 32'd1);
    endtask

    initial begin
        logic [N_REQ-1:0] g [4];
        logic [N_REQ-1:0] g_exp [4];
        int n;
        bit seen;
        bus.req = '0; bus.req_x = '0; bus.req_y = '0; bus.req_w = '0; bus.req_h = '0;
        bus.chk_done = 1'b0; bus.chk_coll = 2'b00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // 1: single request, done two cycles after start with "feet on platform"
        step(); set_ops(0, 500, 600, 64, 64); bus.req = 2'b01;
        step(); mid();
        check("t1_start", 32'(bus.chk_start), 32'd1);
        check("t1_chk_x", 32'(bus.chk_x), 32'd500);
        check("t1_chk_y", 32'(bus.chk_y), 32'd600);
        check("t1_gnt", 32'(bus.gnt), 32'd1);
        step(); mid();
        check("t1_start_once", 32'(bus.chk_start), 32'd0);
        step(); bus.chk_done = 1'b1; bus.chk_coll = 2'b10;
        step(); bus.chk_done = 1'b0; bus.req = 2'b00; mid();
        check("t1_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("t1_rsp_coll", 32'(bus.rsp_coll), 32'd2);
        step(); mid();
        check("t1_idle_busy", 32'(bus.busy), 32'd0);
        check("t1_idle_gnt", 32'(bus.gnt), 32'd0);

        // 2: fresh reset, both requesting, grants must alternate starting at 0
        step(); rst = 1'b0;
        step(); rst = 1'b1;
        set_ops(0, 10, 20, 30, 40); set_ops(1, 50, 60, 70, 80); bus.req = 2'b11;
        g_exp[0] = 2'b01; g_exp[1] = 2'b10; g_exp[2] = 2'b01; g_exp[3] = 2'b10;
        for (int t = 0; t < 4; t++) begin
            wait_start();
            g[t] = bus.gnt;
            step(); bus.chk_done = 1'b1; bus.chk_coll = 2'b01;
            step(); bus.chk_done = 1'b0; mid();
            check("t2_rsp_to_granted", 32'(bus.rsp_valid), 32'(g[t]));
            check("t2_rsp_coll", 32'(bus.rsp_coll), 32'd1);
        end
        for (int t = 0; t < 4; t++) check("t2_grant_order", 32'(g[t]), 32'(g_exp[t]));
        step(); bus.req = 2'b00;

        // 3: checker never answers -> timeout response, sticky error
        step(); set_ops(1, 111, 222, 16, 32); bus.req = 2'b10;
        wait_start();
        n = 0; seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (!seen) begin
                step(); mid(); n++;
                if (bus.rsp_valid != '0) seen = 1'b1;
            end
        end
        check("t3_timeout_cycles", 32'(n), 32'd16);
        check("t3_rsp_valid", 32'(bus.rsp_valid), 32'd2);
        check("t3_rsp_coll", 32'(bus.rsp_coll), 32'd0);
        check("t3_err", 32'(bus.err_timeout), 32'd1);
        step(); bus.req = 2'b00;
        step(); bus.req = 2'b01;
        wait_start();
        step(); bus.chk_done = 1'b1; bus.chk_coll = 2'b10;
        step(); bus.chk_done = 1'b0; bus.req = 2'b00; mid();
        check("t3_good_coll", 32'(bus.rsp_coll), 32'd2);
        check("t3_err_sticky", 32'(bus.err_timeout), 32'd1);

        // 4: operands move and req drops after grant
        step(); set_ops(0, 300, 40, 8, 8); bus.req = 2'b01;
        wait_start();
        check("t4_chk_x", 32'(bus.chk_x), 32'd300);
        step(); set_ops(0, 310, 41, 9, 9); bus.req = 2'b00;
        step(); bus.chk_done = 1'b1; bus.chk_coll = 2'b10;
        step(); bus.chk_done = 1'b0; mid();
        check("t4_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("t4_rsp_coll", 32'(bus.rsp_coll), 32'd2);
        check("t4_chk_x_held", 32'(bus.chk_x), 32'd300);

        // 6: stray done in IDLE and ISSUE is ignored
        step(); bus.chk_done = 1'b1; bus.chk_coll = 2'b11;
        step(); set_ops(0, 5, 6, 7, 8); bus.req = 2'b01;
        step();
        step(); bus.chk_done = 1'b0;
        step(); bus.chk_done = 1'b1; bus.chk_coll = 2'b01;
        step(); bus.chk_done = 1'b0; bus.req = 2'b00; mid();
        check("t6_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("t6_rsp_coll", 32'(bus.rsp_coll), 32'd1);

        // random traffic: requests, operands, done pulses and codes all random
        for (int c = 0; c < 3000; c++) begin
            step();
            bus.req = N_REQ'($urandom_range(0, 3));
            bus.req_x = (N_REQ*COORD_W)'({$urandom, $urandom});
            bus.req_y = (N_REQ*COORD_W)'({$urandom, $urandom});
            bus.req_w = (N_REQ*COORD_W)'({$urandom, $urandom});
            bus.req_h = (N_REQ*COORD_W)'({$urandom, $urandom});
            bus.chk_done = ($urandom_range(0, (c < 1500) ? 3 : 40) == 0);
            bus.chk_coll = 2'($urandom_range(0, 3));
        end
        step(); bus.req = 2'b00; bus.chk_done = 1'b0;
        repeat (25) step();

        // 5: asynchronous reset in WAIT, then lone req[1] is granted first
        set_ops(0, 1, 2, 3, 4); bus.req = 2'b01;
        wait_start();
        step();
        #2 rst = 1'b0;
        #1;
        check("t5_gnt", 32'(bus.gnt), 32'd0);
        check("t5_busy", 32'(bus.busy), 32'd0);
        check("t5_start", 32'(bus.chk_start), 32'd0);
        check("t5_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("t5_err", 32'(bus.err_timeout), 32'd0);
        set_ops(1, 9, 9, 9, 9); bus.req = 2'b10;
        step();
        step(); rst = 1'b1;
        wait_start();
        check("t5_first_gnt", 32'(bus.gnt), 32'd2);
        step(); bus.chk_done = 1'b1; bus.chk_coll = 2'b10;
        step(); bus.chk_done = 1'b0; bus.req = 2'b00; mid();
        check("t5_rsp_valid_after", 32'(bus.rsp_valid), 32'd2);

        step(); mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
